wb_pipe_reg: RTL and testbench
==============================

Name: wb_pipe_reg

Overview:
Parametrised MEM->WB pipeline register, the successor to the fixed 32-bit single-slot stage. It adds a valid/ready handshake, a 2-entry skid buffer for back-pressure from a stalled writeback or register-file port, and a synchronous flush. It also suppresses writes to register x0. It sits between the memory stage and the register-file write port, and its registered outputs drive the forwarding unit.

Parameters:
DATA_W, 32, width of the writeback data
ADDR_W, 5, width of the destination register index
SKID, 1, 1 = 2-entry skid buffer with fully registered in_ready; 0 = single slot with combinational in_ready

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
flush  input  1  synchronous flush; discards all held and incoming entries
in_valid  input  1  MEM stage presents an entry
in_ready  output  1  stage can accept an entry this cycle
in_wd  input  ADDR_W  destination register index
in_wreg  input  1  write-enable request
in_wdata  input  DATA_W  writeback data
out_valid  output  1  entry presented to WB
out_ready  input  1  WB consumes the entry this cycle
out_wd  output  ADDR_W  destination register index
out_wreg  output  1  qualified write enable
out_wdata  output  DATA_W  writeback data
occupancy  output  2  number of held entries (0..2)

Behaviour:
- Clock is clk. Reset rst_n is asynchronous and active-low.
- Reset values: out_valid=0, out_wd=0, out_wreg=0, out_wdata=0, occupancy=0, skid storage=0, state=EMPTY.
- in_ready after reset:
  - SKID=1: in_ready=1 (registered).
  - SKID=0: in_ready=1 (combinational).
- Handshakes:
  - Accept occurs when in_valid & in_ready at a clock edge.
  - Release occurs when out_valid & out_ready at a clock edge.
  - Payload on out_* is stable while out_valid=1 and out_ready=0.
- Latency: an entry accepted at edge N appears on out_* after edge N (1 cycle) when the stage was EMPTY.
- Write qualification is applied at capture: stored wreg = in_wreg & (in_wd != 0). out_wreg is therefore never 1 for x0. wd and wdata still pass through unchanged.
- State machine (SKID=1):
  - EMPTY: accept -> ONE, loading the main register.
  - ONE, accept with no release -> FULL, loading the skid register.
  - ONE, release with no accept -> EMPTY.
  - ONE, accept and release together -> ONE, main register loads the incoming entry.
  - FULL: in_ready=0. Release -> ONE, skid register moves to main. Accept is impossible.
- in_ready (SKID=1) = (next_state != FULL), registered. It depends only on state, never combinationally on out_ready.
- SKID=0:
  - Single main register, states EMPTY/ONE only.
  - in_ready = ~out_valid | out_ready, combinational.
  - Accept and release in the same cycle keeps the stage ONE with the new entry.
- occupancy: EMPTY=0, ONE=1, FULL=2. Registered, updated with state.
- out_valid = 1 in ONE or FULL.
- Flush:
  - At the edge where flush=1, state -> EMPTY, out_valid=0, out_wreg=0, occupancy=0.
  - out_wd and out_wdata are held (don't-care).
  - An entry offered in the same cycle is dropped, even if in_ready=1.
  - A release in the same cycle is lost: WB must treat out_wreg as valid only when out_valid=1.
  - in_ready=1 the cycle after a flush.
- Flush priority: flush > release > accept.
- Reset asserted mid-operation: all state cleared immediately (asynchronous), regardless of the clock.
- Ordering: entries leave in acceptance order; no reordering or duplication.

Decomposition:
- Shared package wb_pkg holds:
  - state encoding localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2;
  - the payload width constant WB_PAYLOAD_W = ADDR_W+1+DATA_W;
  - the x0 index constant REG_ZERO.
- One sub-module is natural: wb_payload_reg, a width-parametrised enable-load register with asynchronous active-low clear. It is instantiated for the main and skid slots. The control FSM stays in wb_pipe_reg.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 mid-cycle with the stage FULL.
  - Response: out_valid=0, out_wreg=0, occupancy=0 immediately; in_ready=1 after release.
- Streaming, out_ready=1:
  - Stimulus: push wd=3/5/7 with wdata=0x11/0x22/0x33 on back-to-back cycles.
  - Response: each appears on out_* one cycle later; throughput 1/cycle; occupancy stays 1.
- Back-pressure (SKID=1):
  - Stimulus: out_ready=0; push A(wd=1, 0xAAAA) and B(wd=2, 0xBBBB).
  - Response: occupancy=2 and in_ready=0 after the 2nd edge; A held stable.
  - Then raise out_ready: A then B released in order; in_ready=1 after A leaves.
- x0 suppression:
  - Stimulus: push in_wd=0, in_wreg=1, in_wdata=0xDEADBEEF.
  - Response: out_valid=1, out_wreg=0, out_wdata=0xDEADBEEF.
- Flush:
  - Stimulus: stage FULL; flush=1 together with in_valid=1 (wd=9).
  - Response: next cycle out_valid=0, occupancy=0, wd=9 never appears, in_ready=1.
- SKID=0 build:
  - Stimulus: out_valid=1, toggle out_ready each cycle.
  - Response: in_ready follows out_ready combinationally in the same cycle; no entry lost or duplicated over 20 random pushes (scoreboard check).

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants and types for the MEM->WB pipeline register.
// State encoding doubles as the occupancy count.
package wb_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_DATA_W   = 32;
  localparam int WB_PAYLOAD_W = DEF_ADDR_W + 1 + DEF_DATA_W;

  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [1:0] {
    EMPTY = ST_EMPTY,
    ONE   = ST_ONE,
    FULL  = ST_FULL
  } wb_state_e;

endpackage

// File: rtl/wb_payload_reg.sv
// Enable-load payload register with asynchronous active-low clear.
// Used for both the main and the skid slot of wb_pipe_reg.
module wb_payload_reg
  import wb_pkg::*;
#(
  parameter int W = WB_PAYLOAD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/wb_pipe_reg.sv
// MEM->WB pipeline register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush and x0 write suppression.
//
// state | meaning
// EMPTY | nothing held, out_valid=0
// ONE   | main slot holds the entry shown on out_*
// FULL  | main and skid slots both held (SKID=1 only), in_ready=0
module wb_pipe_reg
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_wd,
  input  logic              in_wreg,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_wd,
  output logic              out_wreg,
  output logic [DATA_W-1:0] out_wdata,
  output logic [1:0]        occupancy
);

  localparam int PW = ADDR_W + 1 + DATA_W;

  wb_state_e   state_q, state_d;
  logic        acc_fire, rel_fire;
  logic        load_main, load_skid, main_from_skid;
  logic        wreg_qual;
  logic [PW-1:0] in_payload, main_d, main_q, skid_q;

  assign acc_fire = in_valid & in_ready;
  assign rel_fire = out_valid & out_ready;

  // x0 is never written; qualify once at capture so out_wreg needs no decode.
  assign wreg_qual  = in_wreg & (in_wd != ADDR_W'(REG_ZERO));
  assign in_payload = {in_wd, wreg_qual, in_wdata};
  assign main_d     = main_from_skid ? skid_q : in_payload;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc_fire) begin
            state_d   = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (acc_fire && rel_fire) begin
            load_main = 1'b1;
          end else if (acc_fire && (SKID != 0)) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (rel_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (rel_fire) begin
            state_d        = ONE;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  wb_payload_reg #(.W(PW)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_main),
    .d     (main_d),
    .q     (main_q)
  );

  wb_payload_reg #(.W(PW)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_skid),
    .d     (in_payload),
    .q     (skid_q)
  );

  generate
    if (SKID != 0) begin : g_skid_ready
      // Registered so in_ready never depends combinationally on out_ready.
      logic ready_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ready_q <= 1'b1;
        end else begin
          ready_q <= (state_d != FULL);
        end
      end
      assign in_ready = ready_q;
    end else begin : g_comb_ready
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

  assign out_valid = (state_q != EMPTY);
  assign occupancy = state_q;
  assign out_wd    = main_q[PW-1 -: ADDR_W];
  assign out_wreg  = main_q[DATA_W] & out_valid;
  assign out_wdata = main_q[DATA_W-1:0];

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Self-checking bench: SKID=1 and SKID=0 builds side by side, each checked
// against a bounded-FIFO reference model.
module tb_wb_pipe_reg;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  in_wd = '0;
  logic        in_wreg = 1'b0;
  logic [31:0] in_wdata = '0;

  logic        ordy1 = 1'b0, ordy0 = 1'b0;
  logic        rdy1, rdy0, ov1, ov0, owr1, owr0;
  logic [4:0]  owd1, owd0;
  logic [31:0] odat1, odat0;
  logic [1:0]  occ1, occ0;

  ent_t q1[$];
  ent_t q0[$];
  bit   flushed;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  wb_pipe_reg #(.DATA_W(32), .ADDR_W(5), .SKID(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy1), .in_wd(in_wd), .in_wreg(in_wreg),
    .in_wdata(in_wdata), .out_valid(ov1), .out_ready(ordy1), .out_wd(owd1),
    .out_wreg(owr1), .out_wdata(odat1), .occupancy(occ1)
  );

  wb_pipe_reg #(.DATA_W(32), .ADDR_W(5), .SKID(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy0), .in_wd(in_wd), .in_wreg(in_wreg),
    .in_wdata(in_wdata), .out_valid(ov0), .out_ready(ordy0), .out_wd(owd0),
    .out_wreg(owr0), .out_wdata(odat0), .occupancy(occ0)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_side(input string n, input logic v, input logic [1:0] occ,
                            input logic [4:0] wd, input logic wr, input logic [31:0] dat,
                            input int sz, input ent_t head);
    chk({n, ".out_valid"}, 64'(v), 64'(sz > 0));
    chk({n, ".occupancy"}, 64'(occ), 64'(sz));
    if (sz > 0) begin
      chk({n, ".out_wd"}, 64'(wd), 64'(head.wd));
      chk({n, ".out_wreg"}, 64'(wr), 64'(head.wreg));
      chk({n, ".out_wdata"}, 64'(dat), 64'(head.wdata));
    end else if (flushed) begin
      chk({n, ".out_wreg_flush"}, 64'(wr), 64'd0);
    end
  endtask

  task automatic check_outputs();
    ent_t h1, h0;
    h1 = '{default: '0};
    h0 = '{default: '0};
    if (q1.size() > 0) h1 = q1[0];
    if (q0.size() > 0) h0 = q0[0];
    check_side("skid1", ov1, occ1, owd1, owr1, odat1, q1.size(), h1);
    check_side("skid0", ov0, occ0, owd0, owr0, odat0, q0.size(), h0);
  endtask

  // One clock cycle: drive at negedge, check readiness, advance model at posedge,
  // check registered outputs at the following negedge.
  task automatic cycle(input bit v, input logic [4:0] wd, input bit wr,
                       input logic [31:0] dat, input bit fl, input bit r1, input bit r0);
    bit   er1, er0, acc1, acc0, rel1, rel0;
    ent_t e;
    in_valid = v; in_wd = wd; in_wreg = wr; in_wdata = dat;
    flush = fl; ordy1 = r1; ordy0 = r0;
    #1;
    er1 = (q1.size() < 2);
    er0 = (q0.size() == 0) || r0;
    chk("skid1.in_ready", 64'(rdy1), 64'(er1));
    chk("skid0.in_ready", 64'(rdy0), 64'(er0));
    acc1 = v && er1;
    acc0 = v && er0;
    rel1 = (q1.size() > 0) && r1;
    rel0 = (q0.size() > 0) && r0;
    e.wd = wd;
    e.wreg = wr && (wd != 0);
    e.wdata = dat;
    @(posedge clk);
    if (fl) begin
      q1.delete();
      q0.delete();
    end else begin
      if (rel1) void'(q1.pop_front());
      if (acc1) q1.push_back(e);
      if (rel0) void'(q0.pop_front());
      if (acc0) q0.push_back(e);
    end
    flushed = fl;
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    flushed = 1'b1;
    #12;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset.in_ready1", 64'(rdy1), 64'd1);
    chk("reset.in_ready0", 64'(rdy0), 64'd1);

    // streaming
    cycle(1, 5'd3, 1, 32'h11, 0, 1, 1);
    cycle(1, 5'd5, 1, 32'h22, 0, 1, 1);
    cycle(1, 5'd7, 1, 32'h33, 0, 1, 1);
    cycle(0, 5'd0, 0, 32'h0,  0, 1, 1);
    cycle(0, 5'd0, 0, 32'h0,  0, 1, 1);

    // back-pressure
    cycle(1, 5'd1, 1, 32'hAAAA, 0, 0, 0);
    cycle(1, 5'd2, 1, 32'hBBBB, 0, 0, 0);
    cycle(0, 5'd0, 0, 32'h0,    0, 0, 0);
    cycle(0, 5'd0, 0, 32'h0,    0, 1, 1);
    cycle(0, 5'd0, 0, 32'h0,    0, 1, 1);
    cycle(0, 5'd0, 0, 32'h0,    0, 1, 1);

    // x0 suppression
    cycle(1, 5'd0, 1, 32'hDEADBEEF, 0, 0, 0);
    cycle(0, 5'd0, 0, 32'h0,        0, 1, 1);

    // flush while full, with a simultaneous offer
    cycle(1, 5'd4, 1, 32'h44, 0, 0, 0);
    cycle(1, 5'd6, 1, 32'h66, 0, 0, 0);
    cycle(1, 5'd9, 1, 32'h99, 1, 1, 1);
    cycle(0, 5'd0, 0, 32'h0,  0, 1, 1);

    // random traffic; the SKID=0 build sees a toggling out_ready
    for (int i = 0; i < 300; i++) begin
      cycle(bit'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31)),
            bit'($urandom_range(0, 1)), $urandom,
            bit'($urandom_range(0, 19) == 0),
            bit'($urandom_range(0, 2) != 0), bit'(i % 2));
    end

    // asynchronous reset mid-cycle with SKID=1 stage full
    cycle(1, 5'd10, 1, 32'h1010, 0, 0, 0);
    cycle(1, 5'd11, 1, 32'h1111, 0, 0, 0);
    chk("pre_reset.occupancy1", 64'(occ1), 64'd2);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset.out_valid1", 64'(ov1), 64'd0);
    chk("async_reset.out_wreg1", 64'(owr1), 64'd0);
    chk("async_reset.occupancy1", 64'(occ1), 64'd0);
    chk("async_reset.out_valid0", 64'(ov0), 64'd0);
    q1.delete();
    q0.delete();
    @(negedge clk);
    rst_n = 1'b1;
    flushed = 1'b1;
    #1;
    chk("post_reset.in_ready1", 64'(rdy1), 64'd1);
    cycle(1, 5'd12, 1, 32'h1212, 0, 1, 1);
    cycle(0, 5'd0,  0, 32'h0,    0, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
